// File: rtl/alu_pkg.sv
// Shared constants for the RV64I register-register ALU.
package alu_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned SHAMT_W = 6;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage : alu_pkg

// File: rtl/alu_addsub.sv
// 64-bit adder/subtractor shared by ADD, SUB, SLT and SLTU.
module alu_addsub
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            sub,
  output logic [XLEN-1:0] sum_c,
  output logic            carry_c,
  output logic            overflow_c
);

  logic [XLEN-1:0] b_eff;
  logic [XLEN:0]   full;

  // Subtraction as a + ~b + 1; carry-out of 1 means no borrow.
  assign b_eff      = b ^ {XLEN{sub}};
  assign full       = {1'b0, a} + {1'b0, b_eff} + (XLEN + 1)'(sub);
  assign sum_c      = full[XLEN-1:0];
  assign carry_c    = full[XLEN];
  assign overflow_c = (a[XLEN-1] == b_eff[XLEN-1]) && (full[XLEN-1] != a[XLEN-1]);

endmodule : alu_addsub

// File: rtl/rv_alu.sv
// RV64I R-type ALU with a single registered result stage.
module rv_alu
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] rd
);

  logic               sub_c;
  logic [XLEN-1:0]    sum_c;
  logic               carry_c;
  logic               overflow_c;
  logic [SHAMT_W-1:0] shamt;
  logic               is_base;
  logic               is_alt;
  logic               slt_c;
  logic               sltu_c;
  logic [XLEN-1:0]    result_c;

  alu_addsub u_addsub (
    .a          (rs1),
    .b          (rs2),
    .sub        (sub_c),
    .sum_c      (sum_c),
    .carry_c    (carry_c),
    .overflow_c (overflow_c)
  );

  assign shamt   = rs2[SHAMT_W-1:0];
  assign is_base = (funct7 == F7_BASE);
  assign is_alt  = (funct7 == F7_ALT);
  assign slt_c   = sum_c[XLEN-1] ^ overflow_c;
  assign sltu_c  = !carry_c;

  // Decode {funct7, funct3} into the result; unlisted codes give zero.
  always_comb begin
    result_c = '0;
    sub_c    = !(funct3 == F3_ADD_SUB && is_base);
    case (funct3)
      F3_ADD_SUB: if (is_base || is_alt) result_c = sum_c;
      F3_SLL:     if (is_base) result_c = rs1 << shamt;
      F3_SLT:     if (is_base) result_c = XLEN'(slt_c);
      F3_SLTU:    if (is_base) result_c = XLEN'(sltu_c);
      F3_XOR:     if (is_base) result_c = rs1 ^ rs2;
      F3_SRL_SRA: begin
        if (is_base)     result_c = rs1 >> shamt;
        else if (is_alt) result_c = $unsigned($signed(rs1) >>> shamt);
      end
      F3_OR:      if (is_base) result_c = rs1 | rs2;
      F3_AND:     if (is_base) result_c = rs1 & rs2;
      default:    result_c = '0;
    endcase
  end

  // Output register; reset wins over capture.
  always_ff @(posedge clk) begin
    if (rst) rd <= '0;
    else     rd <= result_c;
  end

endmodule : rv_alu

// File: tb/tb_rv_alu.sv
// Directed-vector bench for rv_alu with hand-computed expectations.
module tb_rv_alu;

  logic        clk;
  logic        rst;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic [63:0] rd;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] B = 7'b0000000;
  localparam logic [6:0] A = 7'b0100000;

  rv_alu dut (
    .clk    (clk),
    .rst    (rst),
    .funct3 (funct3),
    .funct7 (funct7),
    .rs1    (rs1),
    .rs2    (rs2),
    .rd     (rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expectation.
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one operation for one cycle and check rd just after the capturing edge.
  task automatic step(input string tag, input logic r, input logic [6:0] f7, input logic [2:0] f3,
                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
    @(negedge clk);
    rst    = r;
    funct7 = f7;
    funct3 = f3;
    rs1    = a;
    rs2    = b;
    @(posedge clk);
    #1;
    check_eq(tag, rd, exp);
  endtask

  initial begin
    rst = 1'b1; funct7 = B; funct3 = 3'b000; rs1 = '0; rs2 = '0;

    // reset, then release
    step("rst_hold",   1'b1, B, 3'b000, 64'd5, 64'd7, 64'h0);
    step("rst_hold2",  1'b1, B, 3'b000, 64'd5, 64'd7, 64'h0);
    step("rst_release",1'b0, B, 3'b000, 64'd5, 64'd7, 64'hC);

    // add/sub
    step("add_wrap",   1'b0, B, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0);
    step("sub_wrap",   1'b0, A, 3'b000, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    step("sub_10_3",   1'b0, A, 3'b000, 64'd10, 64'd3, 64'd7);

    // shifts
    step("sll_43",     1'b0, B, 3'b001, 64'd1, 64'h43, 64'd8);
    step("sll_63",     1'b0, B, 3'b001, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
    step("srl_63",     1'b0, B, 3'b101, 64'h8000_0000_0000_0000, 64'd63, 64'd1);
    step("sra_neg",    1'b0, A, 3'b101, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000);
    step("sra_pos",    1'b0, A, 3'b101, 64'h7000_0000_0000_0000, 64'd4, 64'h0700_0000_0000_0000);
    step("srl_hibits", 1'b0, B, 3'b101, 64'hF0, 64'hFFFF_FFFF_FFFF_FFC4, 64'h0F);

    // compares
    step("slt_m1_1",   1'b0, B, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1);
    step("slt_1_m1",   1'b0, B, 3'b010, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    step("sltu_max_1", 1'b0, B, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    step("sltu_1_max", 1'b0, B, 3'b011, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    step("slt_eq",     1'b0, B, 3'b010, 64'd5, 64'd5, 64'd0);
    step("sltu_eq",    1'b0, B, 3'b011, 64'd9, 64'd9, 64'd0);
    step("slt_ovf",    1'b0, B, 3'b010, 64'h8000_0000_0000_0000, 64'd1, 64'd1);
    step("slt_ovf2",   1'b0, B, 3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0);

    // logic
    step("and",        1'b0, B, 3'b111, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hF000_F000_F000_F000);
    step("or",         1'b0, B, 3'b110, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hFFF0_FFF0_FFF0_FFF0);
    step("xor",        1'b0, B, 3'b100, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0);

    // illegal codes
    step("ill_alt_and",1'b0, A, 3'b111, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'h0);
    step("ill_m_add",  1'b0, 7'b0000001, 3'b000, 64'd5, 64'd7, 64'h0);
    step("ill_alt_sll",1'b0, A, 3'b001, 64'd1, 64'd3, 64'h0);
    step("ill_alt_slt",1'b0, A, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0);

    // mid-stream reset discards the op in flight, next op resumes
    step("add_pre",    1'b0, B, 3'b000, 64'd100, 64'd23, 64'd123);
    step("rst_mid",    1'b1, B, 3'b000, 64'd1, 64'd2, 64'h0);
    step("add_post",   1'b0, B, 3'b000, 64'd1, 64'd2, 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rv_alu
